// File: rtl/phase_time_config.sv
// Phase-time configuration: debounces the start button, times the hold in whole
// seconds and commits the result into the t1/t2/t3 register picked by sw.
module phase_time_config #(
    parameter int unsigned TICK_DIV     = 125000000,
    parameter int unsigned DEBOUNCE_CYC = 1250000,
    parameter logic [3:0]  T1_RST       = 4'd1,
    parameter logic [3:0]  T2_RST       = 4'd5,
    parameter logic [3:0]  T3_RST       = 4'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sw,
    input  logic       start,
    output logic [3:0] t1,
    output logic [3:0] t2,
    output logic [3:0] t3,
    output logic [3:0] led,
    output logic       cfg_upd,
    output logic       busy
);
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;

    typedef enum logic [1:0] {IDLE, MEASURE, COMMIT} state_t;

    logic [1:0]    sync_q;
    logic          btn_db_q;
    logic [DW-1:0] db_cnt_q;
    logic          rise_q;
    logic          fall_q;

    state_t        state_q;
    logic [1:0]    sel_q;
    logic [PW-1:0] presc_q;
    logic [3:0]    timer_q;
    logic [3:0]    timer_d;
    logic [3:0]    commit_val_d;
    logic          tick_c;
    logic [3:0]    t1_q, t2_q, t3_q, led_q;
    logic          cfg_upd_q, busy_q;

    assign t1      = t1_q;
    assign t2      = t2_q;
    assign t3      = t3_q;
    assign led     = led_q;
    assign cfg_upd = cfg_upd_q;
    assign busy    = busy_q;

    // Synchronizer and debouncer; edge pulses fire on the cycle after btn_db changes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q   <= 2'b00;
            btn_db_q <= 1'b0;
            db_cnt_q <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], start};
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (sync_q[1] != btn_db_q) begin
                if (db_cnt_q == DW'(DEBOUNCE_CYC - 1)) begin
                    btn_db_q <= sync_q[1];
                    db_cnt_q <= '0;
                    rise_q   <= sync_q[1];
                    fall_q   <= ~sync_q[1];
                end else begin
                    db_cnt_q <= db_cnt_q + DW'(1);
                end
            end else begin
                db_cnt_q <= '0;
            end
        end
    end

    always_comb begin
        tick_c       = (presc_q == PW'(TICK_DIV - 1));
        timer_d      = (timer_q == 4'd15) ? timer_q : timer_q + 4'd1;
        commit_val_d = (timer_q == 4'd0) ? 4'd1 : timer_q;
    end

    // Measurement FSM; a zero-second hold commits as 1 s.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            sel_q     <= 2'b00;
            presc_q   <= '0;
            timer_q   <= 4'd0;
            t1_q      <= T1_RST;
            t2_q      <= T2_RST;
            t3_q      <= T3_RST;
            led_q     <= 4'd0;
            cfg_upd_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            cfg_upd_q <= 1'b0;
            led_q     <= (state_q == MEASURE) ? timer_q : 4'd0;
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (rise_q && (sw != 2'b00)) begin
                        sel_q   <= sw;
                        timer_q <= 4'd0;
                        presc_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (tick_c) begin
                        presc_q <= '0;
                        timer_q <= timer_d;
                    end else begin
                        presc_q <= presc_q + PW'(1);
                    end
                    if (fall_q) begin
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    case (sel_q)
                        2'b01:   t1_q <= commit_val_d;
                        2'b10:   t2_q <= commit_val_d;
                        2'b11:   t3_q <= commit_val_d;
                        default: ;
                    endcase
                    cfg_upd_q <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_phase_time_config.sv
// Bench for phase_time_config: directed and random button holds checked against
// a seconds-per-hold model of the three phase registers.
module tb_phase_time_config;
    localparam int TICK = 10;
    localparam int DEB  = 4;

    logic       clk;
    logic       rst;
    logic [1:0] sw;
    logic       start;
    logic [3:0] t1, t2, t3, led;
    logic       cfg_upd, busy;

    int n_cmp = 0;
    int n_err = 0;
    int cfg_cnt;
    int busy_seen;
    int led_max;
    int ref_t[4];

    phase_time_config #(
        .TICK_DIV(TICK), .DEBOUNCE_CYC(DEB),
        .T1_RST(4'd1), .T2_RST(4'd5), .T3_RST(4'd1)
    ) dut (
        .clk(clk), .rst(rst), .sw(sw), .start(start),
        .t1(t1), .t2(t2), .t3(t3), .led(led),
        .cfg_upd(cfg_upd), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observes activity between checkpoints.
    always @(negedge clk) begin
        if (cfg_upd === 1'b1) cfg_cnt++;
        if (busy === 1'b1) busy_seen = 1;
        if (int'(led) > led_max) led_max = int'(led);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_mon();
        cfg_cnt   = 0;
        busy_seen = 0;
        led_max   = 0;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".t1"}, 32'(t1), 32'(ref_t[1]));
        chk({tag, ".t2"}, 32'(t2), 32'(ref_t[2]));
        chk({tag, ".t3"}, 32'(t3), 32'(ref_t[3]));
    endtask

    function automatic int secs(input int hold);
        int v;
        v = hold / TICK;
        if (v > 15) v = 15;
        return v;
    endfunction

    // Clean press held for 'hold' cycles; sw switches to s1 after 'chg' cycles.
    task automatic press(input string tag, input logic [1:0] s0, input int hold,
                         input logic [1:0] s1, input int chg);
        int s;
        clr_mon();
        sw    = s0;
        start = 1'b1;
        for (int i = 0; i < hold; i++) begin
            step(1);
            if (i + 1 == chg) sw = s1;
        end
        start = 1'b0;
        step(25);
        s = secs(hold);
        if (s0 != 2'b00) ref_t[int'(s0)] = (s < 1) ? 1 : s;
        chk_regs(tag);
        chk({tag, ".cfg_pulses"}, 32'(cfg_cnt), (s0 != 2'b00) ? 32'd1 : 32'd0);
        chk({tag, ".busy_seen"}, 32'(busy_seen), (s0 != 2'b00) ? 32'd1 : 32'd0);
        chk({tag, ".led_max"}, 32'(led_max), (s0 != 2'b00) ? 32'(s) : 32'd0);
        chk({tag, ".led_idle"}, 32'(led), 32'd0);
        chk({tag, ".busy_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [1:0] rsw;
        int         rh;
        ref_t = '{0, 1, 5, 1};
        clr_mon();
        rst = 1'b0;
        sw = 2'b00;
        start = 1'b0;
        step(3);
        rst = 1'b1;
        step(1);
        chk_regs("reset");
        chk("reset.led", 32'(led), 32'd0);
        chk("reset.cfg_upd", 32'(cfg_upd), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);

        press("prog_t2", 2'b10, 37, 2'b10, 0);

        // Bounce shorter than the debounce window must never register.
        clr_mon();
        sw = 2'b01;
        start = 1'b1; step(3);
        start = 1'b0; step(1);
        start = 1'b1; step(3);
        start = 1'b0; step(20);
        chk_regs("bounce");
        chk("bounce.busy_seen", 32'(busy_seen), 32'd0);
        chk("bounce.cfg_pulses", 32'(cfg_cnt), 32'd0);

        press("zero_time", 2'b01, 6, 2'b01, 0);
        press("sat_latch", 2'b11, 203, 2'b01, 55);
        press("sw_none", 2'b00, 40, 2'b00, 0);
        press("prog_t1", 2'b01, 74, 2'b01, 0);

        for (int k = 0; k < 10; k++) begin
            rsw = 2'($urandom_range(0, 3));
            rh  = TICK * int'($urandom_range(0, 4)) + int'($urandom_range(5, 8));
            press($sformatf("rand%0d_sw%0d_h%0d", k, rsw, rh), rsw, rh, 2'($urandom_range(0, 3)),
                  int'($urandom_range(1, 60)));
        end

        // Asynchronous reset during a measurement discards it.
        press("pre_rst_t3", 2'b11, 95, 2'b11, 0);
        sw = 2'b01;
        start = 1'b1;
        step(45);
        #2 rst = 1'b0;
        #1;
        chk("arst.busy_now", 32'(busy), 32'd0);
        chk("arst.led_now", 32'(led), 32'd0);
        chk("arst.t3_now", 32'(t3), 32'd1);
        ref_t = '{0, 1, 5, 1};
        clr_mon();
        step(2);
        start = 1'b0;
        step(2);
        rst = 1'b1;
        step(25);
        chk_regs("arst");
        chk("arst.cfg_pulses", 32'(cfg_cnt), 32'd0);
        chk("arst.busy_seen", 32'(busy_seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
